// File: rtl/ai_card_pipe.sv
// Card capture FIFO that re-issues each buffered word as a one-cycle strobe DELAY cycles after capture.
// Optional saturating drop counter output is enabled by defining AI_CARD_PIPE_DROP_CNT_EN.
module ai_card_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int DELAY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           card_in,
  input  logic                       card_in_rdy,
  input  logic                       flush,
  input  logic                       ovf_clr,
  output logic [WIDTH-1:0]           card_out,
  output logic                       card_out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       ovf
`ifdef AI_CARD_PIPE_DROP_CNT_EN
  ,
  output logic [7:0]                 drop_cnt
`endif
);

  localparam int PW       = $clog2(DEPTH);
  localparam int LW       = $clog2(DEPTH+1);
  localparam int CW       = (DELAY > 2) ? $clog2(DELAY-1) : 1;
  localparam int CNT_INIT = (DELAY >= 2) ? DELAY-2 : 0;

  typedef enum logic {IDLE, WAIT} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             rdy_nxt;
  logic             pop, push, drop, full, empty;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push = card_in_rdy && !flush && (!full || pop);
  assign drop = card_in_rdy && !flush && full && !pop;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = hold;
    out_nxt   = '0;
    rdy_nxt   = 1'b0;
    pop       = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      hold_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            pop = 1'b1;
            if (DELAY == 1) begin
              out_nxt = mem[rd_ptr];
              rdy_nxt = 1'b1;
            end else begin
              hold_nxt  = mem[rd_ptr];
              cnt_nxt   = CW'(CNT_INIT);
              state_nxt = WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            out_nxt   = hold;
            rdy_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      hold         <= '0;
      card_out     <= '0;
      card_out_rdy <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      hold         <= hold_nxt;
      card_out     <= out_nxt;
      card_out_rdy <= rdy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= card_in;
    end
  end

  // Pointers are PW bits wide, so DEPTH being a power of two makes them wrap for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

`ifdef AI_CARD_PIPE_DROP_CNT_EN
  // A drop on the same edge as a clear restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (ovf_clr) begin
        drop_cnt <= 8'd1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (ovf_clr) begin
      drop_cnt <= '0;
    end
  end
`endif

endmodule

// File: doc/ai_card_pipe.md
Name: ai_card_pipe

Overview:
- Parametrised successor of the single-stage card capture/re-issue block in the AI comparer path.
- Accepts card words on a one-cycle `card_in_rdy` strobe and buffers them in a DEPTH-entry FIFO.
- Re-issues each word as a one-cycle `card_out_rdy` strobe exactly DELAY cycles after capture when the FIFO is uncongested, in order, with overflow detection and a synchronous flush.
- Sits between card producers (feature/decision stages) and the comparer, decoupling bursty producers from comparer timing.

Parameters:
- WIDTH, 8: card word width in bits.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- DELAY, 1: capture-to-output latency in cycles, at least 1; also the minimum spacing between output strobes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- card_in  in  WIDTH  input card word.
- card_in_rdy  in  1  one-cycle strobe; `card_in` is valid on this edge.
- flush  in  1  synchronous flush.
- ovf_clr  in  1  synchronous clear of `ovf`.
- card_out  out  WIDTH  output word; 0 whenever `card_out_rdy`=0.
- card_out_rdy  out  1  one-cycle output strobe.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.
- ovf  out  1  sticky: an input was dropped.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - all outputs are 0;
  - FIFO is empty (read/write pointers 0);
  - engine state is IDLE and the counter is 0.
- All outputs are registered.
- Push: on an edge with `card_in_rdy`=1, `card_in` is written if the FIFO is not full, or if a pop occurs on the same edge.
  - Otherwise the word is dropped and `ovf` is set to 1.
  - `ovf` clears only on an edge with `ovf_clr`=1 and no drop; if a drop and `ovf_clr` coincide, the drop wins.
- Pointers wrap modulo DEPTH.
- `level` updates as follows: +1 on push only, -1 on pop only, unchanged on push+pop.
- Engine states IDLE and WAIT.
  - IDLE, `level`!=0: pop the head.
    - If DELAY=1: on that edge set `card_out`=head, `card_out_rdy`=1, and stay in IDLE (may pop again next edge).
    - Else: hold=head, cnt=DELAY-2, go to WAIT.
  - WAIT: if cnt=0, set `card_out`=hold, `card_out_rdy`=1, go to IDLE; else cnt decrements.
  - Every other edge: `card_out_rdy`=0 and `card_out`=0.
- Latency: a word pushed at edge E0 into an empty FIFO with the engine in IDLE drives `card_out_rdy`=1 for exactly the cycle following edge E0+DELAY.
- Throughput: one word per DELAY cycles; back-to-back strobes occur when DELAY=1.
- The engine never pops on the edge a word is written; the earliest pop of a word is the following edge.
- Flush (priority below reset, above everything else):
  - FIFO emptied, `level`=0, state IDLE, `card_out_rdy`=0, `card_out`=0.
  - A concurrent `card_in_rdy` is discarded and does not set `ovf`.
  - `ovf` is unaffected, except that a concurrent `ovf_clr` still applies.
- Reset asserted mid-WAIT aborts the pending word; it is never emitted.

Optional Feature:
- Macro: AI_CARD_PIPE_DROP_CNT_EN.
- Defined: adds output `drop_cnt` (out, 8 bits).
  - Increments once per dropped input and saturates at 255.
  - Cleared by reset and by `ovf_clr`; `flush` does not clear it.
  - A drop coinciding with `ovf_clr` sets `drop_cnt` to 1.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan (WIDTH=8, DEPTH=4, DELAY=3 unless noted):
- Single push 0xA5 at E0 -> `level`=1 after E0, 0 after E1; `card_out_rdy`=1 with `card_out`=0xA5 only in the cycle after E3; `card_out`=0 otherwise.
- Pushes 0x01..0x04 at E0..E3 -> strobes after E3, E6, E9, E12 carrying 0x01..0x04 in order; `ovf` stays 0.
- Pushes 0x10..0x17 on E0..E7:
  - 0x16 is dropped at E6, with `ovf`=1 after E6 (`drop_cnt`=1 if enabled).
  - At E7, push and pop coincide and `level` stays 4.
  - Outputs are 0x10..0x15 then 0x17.
  - `ovf_clr` at E20 -> `ovf`=0.
- DELAY=1, pushes 0x20..0x27 every cycle E0..E7 -> strobes in the cycles after E1..E8 with matching data; `level` never exceeds 1.
- Push 0x55 at E0, `flush` at E2 (mid-WAIT), with `card_in_rdy`=1 and 0x66 at E2 -> no output strobe ever; `level`=0 after E2; `ovf`=0.
- Push 0x77 at E0, assert `rst` asynchronously between E1 and E2 -> all outputs 0 immediately; 0x77 is never emitted; normal operation resumes after release.
